// File: rtl/rssb_alu.sv
// rtl/rssb_alu.sv - RSSB execute stage: operand select, reverse subtract, borrow, halt detect, stats
module rssb_alu #(
    parameter int BW       = 1,
    parameter int HALT_LEN = 3,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [BW-1:0] data [1:0],
    output logic [BW-1:0] result,
    output logic          flag,
    output logic [BW-1:0] acc,
    output logic          halted,
    output logic [CW-1:0] retired,
    output logic [CW-1:0] skipped
);

    // HALT_LEN is bounded to 1..15, so a 4-bit run counter always suffices.
    localparam int            RCW      = 4;
    localparam logic [RCW-1:0] HALT_CNT = RCW'(HALT_LEN);
    localparam logic [BW-1:0]  OP_ONES  = '1;
    localparam logic [CW-1:0]  CNT_MAX  = '1;

    logic [BW-1:0]  r_acc;
    logic           r_skip;
    logic [RCW-1:0] r_run_cnt;
    logic           r_halted;
    logic [CW-1:0]  r_retired;
    logic [CW-1:0]  r_skipped;

    logic [BW-1:0]  w_op;
    logic           w_active;
    logic           w_op_ones;
    logic [RCW-1:0] w_run_next;

    // The skip state mirrors the memory stage's pc skip, so it alone picks
    // which of the two fetched operands belongs to the executing instruction.
    assign w_op       = r_skip ? data[1] : data[0];
    assign w_active   = ena & ~r_halted;
    assign w_op_ones  = (w_op == OP_ONES);
    assign w_run_next = (r_run_cnt >= HALT_CNT) ? HALT_CNT : (r_run_cnt + RCW'(1));

    // Write-back value and borrow; idle cycles write the operand back unchanged.
    always_comb begin
        result = w_op;
        flag   = 1'b0;
        if (rst) begin
            result = data[0];
        end else if (w_active) begin
            result = w_op - r_acc;
            flag   = (w_op < r_acc);
        end
    end

    // Skip state follows flag every cycle, idle ones included, so a skip
    // raised on the halting edge drains after one idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skip <= 1'b0;
        end else begin
            r_skip <= flag;
        end
    end

    // Accumulator takes the subtraction result on executed instructions only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_active) begin
            r_acc <= result;
        end
    end

    // Retire/skip statistics, saturating so long runs never wrap to small values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
            r_skipped <= '0;
        end else if (w_active) begin
            if (r_retired != CNT_MAX) begin
                r_retired <= r_retired + CW'(1);
            end
            if (r_skip && (r_skipped != CNT_MAX)) begin
                r_skipped <= r_skipped + CW'(1);
            end
        end
    end

    // Halt detector: a run of HALT_LEN executed all-ones operands halts the
    // core; the last instruction of the run still executes on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_cnt <= '0;
            r_halted  <= 1'b0;
        end else if (w_active) begin
            if (w_op_ones) begin
                r_run_cnt <= w_run_next;
                if (w_run_next == HALT_CNT) begin
                    r_halted <= 1'b1;
                end
            end else begin
                r_run_cnt <= '0;
            end
        end
    end

    assign acc     = r_acc;
    assign halted  = r_halted;
    assign retired = r_retired;
    assign skipped = r_skipped;

endmodule

// File: tb/tb_rssb_alu.sv
// tb/tb_rssb_alu.sv - scoreboard bench for rssb_alu with directed vectors
module tb_rssb_alu;

    localparam int BW = 1;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          ena;
    logic [BW-1:0] data [1:0];
    logic [BW-1:0] result;
    logic          flag;
    logic [BW-1:0] acc;
    logic          halted;
    logic [CW-1:0] retired;
    logic [CW-1:0] skipped;

    rssb_alu #(.BW(BW), .HALT_LEN(3), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .data    (data),
        .result  (result),
        .flag    (flag),
        .acc     (acc),
        .halted  (halted),
        .retired (retired),
        .skipped (skipped)
    );

    typedef struct {
        string         nm;
        logic [BW-1:0] r;
        logic          f;
        logic [BW-1:0] a;
        logic          h;
        logic [CW-1:0] ret;
        logic [CW-1:0] skp;
        bit            crun;
        logic [3:0]    run;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: observes outputs 2 time units after each falling edge and
    // scores them against whatever the driver queued for that cycle.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.nm, "result",  32'(result),  32'(e.r));
            chk(e.nm, "flag",    32'(flag),    32'(e.f));
            chk(e.nm, "acc",     32'(acc),     32'(e.a));
            chk(e.nm, "halted",  32'(halted),  32'(e.h));
            chk(e.nm, "retired", 32'(retired), 32'(e.ret));
            chk(e.nm, "skipped", 32'(skipped), 32'(e.skp));
            if (e.crun) chk(e.nm, "run_cnt", 32'(dut.r_run_cnt), 32'(e.run));
        end
    end

    // One stimulus cycle: drive at the falling edge and queue the expectation.
    task automatic cyc(input string nm, input bit r, input bit e, input bit d0, input bit d1,
                       input bit er, input bit ef, input bit ea, input bit eh,
                       input int eret, input int eskp, input bit crun, input int erun,
                       input bit frc);
        exp_t x;
        @(negedge clk);
        rst     = r;
        ena     = e;
        data[0] = d0;
        data[1] = d1;
        if (frc) begin
            force dut.r_retired = {CW{1'b1}};
            #1;
            release dut.r_retired;
        end
        x.nm = nm; x.r = er; x.f = ef; x.a = ea; x.h = eh;
        x.ret = CW'(eret); x.skp = CW'(eskp); x.crun = crun; x.run = 4'(erun);
        exp_q.push_back(x);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; data[0] = '0; data[1] = '0;
        //   name         rst ena d0 d1  res flg acc hlt ret    skp crun run frc
        cyc("rst_hold",   1,  1,  1, 0,  1,  0,  0,  0,  0,     0,  1,  0,  0);
        cyc("exec1",      0,  1,  1, 0,  1,  0,  0,  0,  0,     0,  1,  0,  0);
        cyc("idle1",      0,  0,  1, 0,  1,  0,  1,  0,  1,     0,  1,  1,  0);
        cyc("borrow",     0,  1,  0, 1,  1,  1,  1,  0,  1,     0,  1,  1,  0);
        cyc("skipsel",    0,  1,  0, 1,  0,  0,  1,  0,  2,     0,  1,  0,  0);
        cyc("after_skip", 0,  1,  0, 0,  0,  0,  0,  0,  3,     1,  1,  1,  0);
        cyc("exec2",      0,  1,  1, 0,  1,  0,  0,  0,  4,     1,  1,  0,  0);
        cyc("idle2",      0,  0,  1, 0,  1,  0,  1,  0,  5,     1,  1,  1,  0);
        cyc("async_rst",  1,  1,  1, 0,  1,  0,  0,  0,  0,     0,  1,  0,  0);
        cyc("halt_a",     0,  1,  1, 0,  1,  0,  0,  0,  0,     0,  1,  0,  0);
        cyc("halt_b",     0,  1,  1, 0,  0,  0,  1,  0,  1,     0,  1,  1,  0);
        cyc("halt_c",     0,  1,  1, 0,  1,  0,  0,  0,  2,     0,  1,  2,  0);
        cyc("halted",     0,  1,  0, 1,  0,  0,  1,  1,  3,     0,  1,  3,  0);
        cyc("halt_frz",   0,  1,  1, 0,  1,  0,  1,  1,  3,     0,  1,  3,  0);
        cyc("rst2",       1,  1,  0, 1,  0,  0,  0,  0,  0,     0,  1,  0,  0);
        cyc("brk1",       0,  1,  1, 0,  1,  0,  0,  0,  0,     0,  1,  0,  0);
        cyc("brk2",       0,  1,  1, 0,  0,  0,  1,  0,  1,     0,  1,  1,  0);
        cyc("brk3",       0,  1,  0, 1,  0,  0,  0,  0,  2,     0,  1,  2,  0);
        cyc("brk4",       0,  1,  1, 0,  1,  0,  0,  0,  3,     0,  1,  0,  0);
        cyc("brk5",       0,  1,  1, 0,  0,  0,  1,  0,  4,     0,  1,  1,  0);
        cyc("brk_end",    0,  0,  0, 0,  0,  0,  0,  0,  5,     0,  1,  2,  0);
        cyc("sat_pre",    0,  1,  0, 0,  0,  0,  0,  0,  65535, 0,  0,  0,  1);
        cyc("sat_hold",   0,  0,  0, 0,  0,  0,  0,  0,  65535, 0,  1,  0,  0);
        @(negedge clk);
        ena = 1'b0;
        #5;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
